// File: rtl/riscy_pkg.sv
// Shared RV32I load/store constants and the LSU state type.
package riscy_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE   = 2'd0;
    localparam lsu_state_t ACCESS = 2'd1;
    localparam lsu_state_t FINISH = 2'd2;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-addressed memory bus between the LSU (master) and memory (slave).
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Load lane select and sign/zero extension of a fetched memory word.
module lsu_align
    import riscy_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = '0;
        case (offset)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = '0;
        endcase
        // Halfword lane uses offset[1] only; offset[0] is ignored here.
        half_v = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_B:  data = {{24{byte_v[7]}}, byte_v};
            F3_BU: data = {24'd0, byte_v};
            F3_H:  data = {{16{half_v[15]}}, half_v};
            F3_HU: data = {16'd0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one memory op per start, word-aligned bus with byte strobes.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them down.
module lsu
    import riscy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] rs2_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    lsu_if.master       mem
);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        req_fault;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] aligned;

    always_comb begin
        req_fault = (is_load == is_store) || !f3_legal(is_store, funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((funct3[1:0] == 2'b01 && address[0]) ||
            (funct3[1:0] == 2'b10 && address[1:0] != 2'b00))
            req_fault = 1'b1;
`endif

        st_wstrb = 4'b1111;
        st_wdata = rs2_val;
        case (funct3)
            F3_B: begin
                st_wstrb = 4'b0001 << address[1:0];
                st_wdata = {4{rs2_val[7:0]}};
            end
            F3_H: begin
                st_wstrb = 4'b0011 << {address[1], 1'b0};
                st_wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = rs2_val;
            end
        endcase
    end

    lsu_align u_align (
        .funct3 (f3_q),
        .offset (off_q),
        .rdata  (mem.mem_rdata),
        .data   (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            load_data     <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (req_fault) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        fault <= 1'b1;
                    end else begin
                        state         <= ACCESS;
                        f3_q          <= funct3;
                        off_q         <= address[1:0];
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= is_store;
                        mem.mem_addr  <= {address[31:2], 2'b00};
                        mem.mem_wstrb <= is_store ? st_wstrb : 4'b0000;
                        mem.mem_wdata <= is_store ? st_wdata : 32'd0;
                    end
                end
                ACCESS: if (mem.mem_ready) begin
                    state       <= FINISH;
                    done        <= 1'b1;
                    mem.mem_req <= 1'b0;
                    if (!mem.mem_we)
                        load_data <= aligned;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus queues expected bus requests and completions, monitors compare.
module tb_lsu;
    import riscy_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic        flt;
        logic [31:0] data;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] address = '0;
    logic [31:0] rs2_val = '0;
    logic        busy, done, fault;
    logic [31:0] load_data;

    lsu_if mem_bus ();

    lsu dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_load   (is_load),
        .is_store  (is_store),
        .funct3    (funct3),
        .address   (address),
        .rs2_val   (rs2_val),
        .busy      (busy),
        .done      (done),
        .load_data (load_data),
        .fault     (fault),
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          ready_cyc = 0;
    logic [31:0] model_ld = '0;
    bus_exp_t    exp_bus[$];
    done_exp_t   exp_done[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Bus monitor: checks each new request against the queue and holds it stable while pending.
    initial begin
        logic     req_prev;
        bus_exp_t held, eb;
        req_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req === 1'b1) begin
                if (!req_prev) begin
                    if (exp_bus.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        eb = exp_bus.pop_front();
                        chk("req_latency", 32'(cyc), 32'(start_cyc + 1));
                        chk("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, eb.we});
                        chk("mem_addr", mem_bus.mem_addr, eb.addr);
                        chk("mem_wstrb", {28'd0, mem_bus.mem_wstrb}, {28'd0, eb.wstrb});
                        if (eb.we)
                            chk("mem_wdata", mem_bus.mem_wdata, eb.wdata);
                    end
                    held = '{mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wstrb, mem_bus.mem_wdata};
                end else begin
                    chk("req_stable_addr", mem_bus.mem_addr, held.addr);
                    chk("req_stable_ctl", {27'd0, mem_bus.mem_we, mem_bus.mem_wstrb},
                        {27'd0, held.we, held.wstrb});
                    chk("req_stable_wdata", mem_bus.mem_wdata, held.wdata);
                end
                if (mem_bus.mem_ready === 1'b1)
                    ready_cyc = cyc;
            end
            req_prev = (mem_bus.mem_req === 1'b1);
        end
    end

    // Completion monitor: every done pulse must match the next queued result.
    initial begin
        done_exp_t ed;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ed = exp_done.pop_front();
                    chk("fault", {31'd0, fault}, {31'd0, ed.flt});
                    chk("load_data", load_data, ed.data);
                    if (ed.flt) begin
                        chk("fault_done_latency", 32'(cyc), 32'(start_cyc + 1));
                    end else begin
                        chk("done_latency", 32'(cyc), 32'(ready_cyc + 1));
                        chk("req_dropped", {31'd0, mem_bus.mem_req}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; address = '0; rs2_val = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rd, input int lat, input logic flt,
                         input logic [31:0] exp_ld, input logic [3:0] ewstrb,
                         input logic [31:0] ewdata, input bit poke);
        if (!flt) begin
            exp_bus.push_back('{st, {addr[31:2], 2'b00}, ewstrb, ewdata});
            if (ld) model_ld = exp_ld;
        end
        exp_done.push_back('{flt, model_ld});

        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b1; is_load = ld; is_store = st;
        funct3 = f3; address = addr; rs2_val = rs2;
        @(posedge clk); #1;
        drive_idle();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (!flt) begin
            for (int i = 0; i < lat; i++) begin
                if (poke && i == 0) begin
                    start = 1'b1; is_store = 1'b1; funct3 = F3_B;
                    address = 32'h300; rs2_val = 32'h77;
                end
                @(posedge clk); #1;
                drive_idle();
            end
            mem_bus.mem_ready = 1'b1;
            mem_bus.mem_rdata = rd;
            @(posedge clk); #1;
            mem_bus.mem_ready = 1'b0;
            mem_bus.mem_rdata = '0;
        end
        wait_idle();
    endtask

    initial begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
        chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_bus.mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        rst = 1'b0;

        // Stores: SW, SB lane 3, SH upper half
        issue(0, 1, F3_W, 32'h100, 32'hDEADBEEF, 0, 3, 0, 0, 4'b1111, 32'hDEADBEEF, 0);
        issue(0, 1, F3_B, 32'h103, 32'h000000A5, 0, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
        issue(0, 1, F3_H, 32'h102, 32'h1234BEEF, 0, 1, 0, 0, 4'b1100, 32'hBEEFBEEF, 0);

        // Loads with extension
        issue(1, 0, F3_B,  32'h102, 0, 32'h12F45678, 2, 0, 32'hFFFFFFF4, 4'b0000, 0, 0);
        issue(1, 0, F3_BU, 32'h102, 0, 32'h12F45678, 1, 0, 32'h000000F4, 4'b0000, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1, 0, F3_H,  32'h101, 0, 32'h1234ABCD, 1, 1, 0, 4'b0000, 0, 0);
`else
        issue(1, 0, F3_H,  32'h101, 0, 32'h1234ABCD, 1, 0, 32'hFFFFABCD, 4'b0000, 0, 0);
`endif
        issue(1, 0, F3_HU, 32'h202, 0, 32'h80010000, 0, 0, 32'h00008001, 4'b0000, 0, 0);
        issue(1, 0, F3_W,  32'h204, 0, 32'hCAFEF00D, 2, 0, 32'hCAFEF00D, 4'b0000, 0, 1);
        issue(1, 0, F3_B,  32'h001, 0, 32'h00008000, 1, 0, 32'hFFFFFF80, 4'b0000, 0, 0);

        // Stray mem_ready while no request is outstanding
        @(posedge clk); #1;
        mem_bus.mem_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        mem_bus.mem_ready = 1'b0;
        chk("stray_ready_no_busy", {31'd0, busy}, 32'd0);

        // Faulting requests: both flags, neither flag, illegal funct3
        issue(1, 1, F3_W,      32'h40, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        issue(0, 0, F3_W,      32'h40, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        issue(1, 0, 3'b011,    32'h40, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        issue(0, 1, F3_BU,     32'h40, 0, 0, 0, 1, 0, 4'b0000, 0, 0);

        // Reset while a load waits on the bus
        exp_bus.push_back('{1'b0, 32'h400, 4'b0000, 32'd0});
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b1; is_load = 1'b1; funct3 = F3_W; address = 32'h400;
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
        chk("pending_req", {31'd0, mem_bus.mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_drops_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rst_drops_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_ld = '0;
        issue(1, 0, F3_W, 32'h10, 0, 32'h55AA55AA, 1, 0, 32'h55AA55AA, 4'b0000, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
